demux3_1_stage: RTL

- Registered 1-to-3 router with valid/ready handshakes, the distribution counterpart of the 3:1 select muxes in the 16-bit MIPS datapath.
- Takes one word plus a 2-bit destination select and delivers it to exactly one of three consumers, for example data memory, I/O or the writeback path.
- A single holding register gives 1-cycle latency and full throughput, with backpressure from the selected consumer only.

---
 rtl/demux3_1_stage_pkg.sv | 23 ++
 rtl/demux3_1_stage_sat_counter.sv | 25 ++
 rtl/demux3_1_stage.sv | 111 +++++++++++
 3 files changed

// File: rtl/demux3_1_stage_pkg.sv
// Shared destination encodings and select decode for the 1-to-3 routing stage.
package demux3_1_stage_pkg;

    localparam logic [1:0] SEL_OUT0    = 2'b00;
    localparam logic [1:0] SEL_OUT1    = 2'b01;
    localparam logic [1:0] SEL_OUT2    = 2'b10;
    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    localparam int BITS_DEFAULT = 16;

    // The illegal code falls through to out0, like the default leg of a 3:1 mux.
    function automatic logic [1:0] dest_of(input logic [1:0] sel_v);
        logic [1:0] dest_v;
        case (sel_v)
            SEL_OUT0: dest_v = SEL_OUT0;
            SEL_OUT1: dest_v = SEL_OUT1;
            SEL_OUT2: dest_v = SEL_OUT2;
            default:  dest_v = SEL_OUT0;
        endcase
        return dest_v;
    endfunction

endpackage

// File: rtl/demux3_1_stage_sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] CNT_ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX = {WIDTH{1'b1}};

    // Count increment events, sticking at the maximum value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= {WIDTH{1'b0}};
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end else begin
            count <= count;
        end
    end

endmodule

// File: rtl/demux3_1_stage.sv
// Registered 1-to-3 router: one holding register, 1-cycle latency, full throughput,
// backpressure taken only from the destination currently held.
module demux3_1_stage
    import demux3_1_stage_pkg::*;
#(
    parameter int BITS = BITS_DEFAULT,
    parameter int ERRW = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      sel,
    input  logic [BITS-1:0] in_data,
    output logic            out0_valid,
    output logic            out1_valid,
    output logic            out2_valid,
    input  logic            out0_ready,
    input  logic            out1_ready,
    input  logic            out2_ready,
    output logic [BITS-1:0] out0_data,
    output logic [BITS-1:0] out1_data,
    output logic [BITS-1:0] out2_data,
    output logic            sel_err,
    output logic [ERRW-1:0] err_cnt
);

    logic            hold_valid_r;
    logic [1:0]      hold_dest_r;
    logic [BITS-1:0] hold_data_r;

    logic            drain_s;
    logic            in_ready_s;
    logic            accept_s;
    logic            illegal_s;
    logic            nx_valid_s;
    logic [1:0]      nx_dest_s;
    logic [BITS-1:0] nx_data_s;

    // Drain uses only the ready of the port the held word is routed to.
    always_comb begin
        drain_s = 1'b0;
        case (hold_dest_r)
            SEL_OUT0: drain_s = out0_valid & out0_ready;
            SEL_OUT1: drain_s = out1_valid & out1_ready;
            SEL_OUT2: drain_s = out2_valid & out2_ready;
            default:  drain_s = 1'b0;
        endcase
        in_ready_s = !flush && (!hold_valid_r || drain_s);
        accept_s   = in_valid && in_ready_s;
        illegal_s  = accept_s && (sel == SEL_ILLEGAL);
    end

    assign in_ready = in_ready_s;

    // Next holding-register contents; flush wins and blocks any accept.
    always_comb begin
        nx_valid_s = hold_valid_r;
        nx_dest_s  = hold_dest_r;
        nx_data_s  = hold_data_r;
        if (flush) begin
            nx_valid_s = 1'b0;
        end else if (accept_s) begin
            nx_valid_s = 1'b1;
            nx_dest_s  = dest_of(sel);
            nx_data_s  = in_data;
        end else if (drain_s) begin
            nx_valid_s = 1'b0;
        end else begin
            nx_valid_s = hold_valid_r;
        end
    end

    // Hold state plus per-port outputs, decoded ahead of the edge so each output is a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_valid_r <= 1'b0;
            hold_dest_r  <= SEL_OUT0;
            hold_data_r  <= {BITS{1'b0}};
            out0_valid   <= 1'b0;
            out1_valid   <= 1'b0;
            out2_valid   <= 1'b0;
            out0_data    <= {BITS{1'b0}};
            out1_data    <= {BITS{1'b0}};
            out2_data    <= {BITS{1'b0}};
            sel_err      <= 1'b0;
        end else begin
            hold_valid_r <= nx_valid_s;
            hold_dest_r  <= nx_dest_s;
            hold_data_r  <= nx_data_s;
            out0_valid   <= nx_valid_s && (nx_dest_s == SEL_OUT0);
            out1_valid   <= nx_valid_s && (nx_dest_s == SEL_OUT1);
            out2_valid   <= nx_valid_s && (nx_dest_s == SEL_OUT2);
            out0_data    <= (nx_valid_s && (nx_dest_s == SEL_OUT0)) ? nx_data_s : {BITS{1'b0}};
            out1_data    <= (nx_valid_s && (nx_dest_s == SEL_OUT1)) ? nx_data_s : {BITS{1'b0}};
            out2_data    <= (nx_valid_s && (nx_dest_s == SEL_OUT2)) ? nx_data_s : {BITS{1'b0}};
            sel_err      <= illegal_s;
        end
    end

    sat_counter #(
        .WIDTH (ERRW)
    ) u_err_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (illegal_s),
        .count (err_cnt)
    );

endmodule
